// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout hit arbiter slice.
//   state_t              : arbiter FSM state encoding
//   COOL_FRAMES_DEFAULT  : frame ticks of hit cooldown after a bounce
//   BLK_PER_COL_DEFAULT  : blocks per column, used for clear detection
package breakout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_COOL  = 2'd2
  } state_t;

  localparam int unsigned COOL_FRAMES_DEFAULT = 2;
  localparam int unsigned BLK_PER_COL_DEFAULT = 8;

endpackage

// File: rtl/breakout_hit_arbiter_rr_select.sv
// Round-robin first-set-bit selector (purely combinational).
//   req   : request vector, one bit per column
//   ptr   : index where the search starts, wrapping modulo N_COLS
//   valid : at least one request bit is set
//   idx   : index of the first set bit at or after ptr
module rr_select #(
  parameter int unsigned N_COLS = 8,
  localparam int unsigned IW = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
  input  logic [N_COLS-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic              valid,
  output logic [IW-1:0]     idx
);

  int unsigned j;
  logic [IW-1:0] jj;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    jj    = '0;
    for (int unsigned k = 0; k < N_COLS; k++) begin
      j  = (32'(ptr) + k) % N_COLS;
      jj = IW'(j);
      if (!valid && req[jj]) begin
        valid = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/breakout_hit_arbiter.sv
// Collects block-column hit flags, grants one column round-robin, applies its
// direction flags to the ball, then ignores new hits for a frame-based
// cooldown. Also sums per-column hit counts into a score.
//   clk, reset            : clock, synchronous active-high reset
//   frame_tick            : one-cycle pulse per video frame
//   col_up/dn/lf/rt       : per-column move flags
//   col_count             : per-column 4-bit hit counts, packed
//   dir_x, dir_y          : ball direction (1 = right / 1 = down)
//   bounce                : one-cycle pulse when a direction update lands
//   grant_col             : column granted on the latest bounce
//   score, all_clear      : registered hit sum and "every block hit" flag
//   drop_cnt              : saturating count of hits dropped in cooldown
module breakout_hit_arbiter
  import breakout_pkg::*;
#(
  parameter int unsigned N_COLS      = 8,
  parameter int unsigned COOL_FRAMES = COOL_FRAMES_DEFAULT,
  parameter int unsigned BLK_PER_COL = BLK_PER_COL_DEFAULT,
  localparam int unsigned IW = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic [N_COLS-1:0]     col_up,
  input  logic [N_COLS-1:0]     col_dn,
  input  logic [N_COLS-1:0]     col_lf,
  input  logic [N_COLS-1:0]     col_rt,
  input  logic [4*N_COLS-1:0]   col_count,
  output logic                  dir_x,
  output logic                  dir_y,
  output logic                  bounce,
  output logic [IW-1:0]         grant_col,
  output logic [7:0]            score,
  output logic                  all_clear,
  output logic [7:0]            drop_cnt
);

  localparam logic [7:0] COOL_LOAD  = 8'(COOL_FRAMES);
  localparam logic [7:0] ALL_BLOCKS = 8'(N_COLS * BLK_PER_COL);

  state_t            state_q, state_d;
  logic [7:0]        cool_q, cool_d;
  logic              dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic              bounce_q, bounce_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     gsel_q, gsel_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              up_q, up_d, dn_q, dn_d, lf_q, lf_d, rt_q, rt_d;
  logic [7:0]        score_q, score_d;
  logic [7:0]        drop_q, drop_d;
  logic [N_COLS-1:0] req_prev_q, req_prev_d;

  logic [N_COLS-1:0] req;
  logic              rr_valid;
  logic [IW-1:0]     rr_idx;

  assign req = col_up | col_dn | col_lf | col_rt;

  rr_select #(.N_COLS(N_COLS)) u_rr_select (
    .req   (req),
    .ptr   (rr_ptr_q),
    .valid (rr_valid),
    .idx   (rr_idx)
  );

  // State register (all flops)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cool_q     <= '0;
      dir_x_q    <= 1'b1;
      dir_y_q    <= 1'b0;
      bounce_q   <= 1'b0;
      grant_q    <= '0;
      gsel_q     <= '0;
      rr_ptr_q   <= '0;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
      lf_q       <= 1'b0;
      rt_q       <= 1'b0;
      score_q    <= '0;
      drop_q     <= '0;
      req_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      cool_q     <= cool_d;
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
      bounce_q   <= bounce_d;
      grant_q    <= grant_d;
      gsel_q     <= gsel_d;
      rr_ptr_q   <= rr_ptr_d;
      up_q       <= up_d;
      dn_q       <= dn_d;
      lf_q       <= lf_d;
      rt_q       <= rt_d;
      score_q    <= score_d;
      drop_q     <= drop_d;
      req_prev_q <= req_prev_d;
    end
  end

  // Next-state and cooldown counter
  always_comb begin
    state_d = state_q;
    cool_d  = cool_q;
    unique case (state_q)
      ST_IDLE:  if (rr_valid) state_d = ST_APPLY;
      ST_APPLY: begin
        // A frame_tick here is ignored: the counter is only loaded.
        state_d = ST_COOL;
        cool_d  = COOL_LOAD;
      end
      ST_COOL: begin
        if (cool_q == '0) begin
          state_d = ST_IDLE;
        end else if (frame_tick) begin
          cool_d = cool_q - 8'd1;
          if (cool_q == 8'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath / outputs
  always_comb begin
    dir_x_d    = dir_x_q;
    dir_y_d    = dir_y_q;
    bounce_d   = 1'b0;
    grant_d    = grant_q;
    gsel_d     = gsel_q;
    rr_ptr_d   = rr_ptr_q;
    up_d       = up_q;
    dn_d       = dn_q;
    lf_d       = lf_q;
    rt_d       = rt_q;
    drop_d     = drop_q;
    req_prev_d = req;
    score_d    = '0;
    for (int unsigned i = 0; i < N_COLS; i++) begin
      score_d = score_d + 8'(col_count[4*i +: 4]);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rr_valid) begin
          gsel_d   = rr_idx;
          up_d     = col_up[rr_idx];
          dn_d     = col_dn[rr_idx];
          lf_d     = col_lf[rr_idx];
          rt_d     = col_rt[rr_idx];
          rr_ptr_d = (rr_idx == IW'(N_COLS - 1)) ? '0 : rr_idx + 1'b1;
        end
      end
      ST_APPLY: begin
        // Opposing flags on one axis cancel and leave that axis untouched.
        if (rt_q && !lf_q) dir_x_d = 1'b1;
        if (lf_q && !rt_q) dir_x_d = 1'b0;
        if (up_q && !dn_q) dir_y_d = 1'b0;
        if (dn_q && !up_q) dir_y_d = 1'b1;
        bounce_d = 1'b1;
        grant_d  = gsel_q;
      end
      ST_COOL: begin
        if (|(req & ~req_prev_q) && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
      end
      default: ;
    endcase
  end

  assign dir_x     = dir_x_q;
  assign dir_y     = dir_y_q;
  assign bounce    = bounce_q;
  assign grant_col = grant_q;
  assign score     = score_q;
  assign all_clear = (score_q == ALL_BLOCKS);
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_breakout_hit_arbiter.sv
module tb_breakout_hit_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic [7:0]  col_up, col_dn, col_lf, col_rt;
  logic [31:0] col_count;
  logic        dir_x, dir_y, bounce, all_clear;
  logic [2:0]  grant_col;
  logic [7:0]  score, drop_cnt;

  int vectors    = 0;
  int miscompares = 0;

  breakout_hit_arbiter #(.N_COLS(8), .COOL_FRAMES(2), .BLK_PER_COL(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .col_up     (col_up),
    .col_dn     (col_dn),
    .col_lf     (col_lf),
    .col_rt     (col_rt),
    .col_count  (col_count),
    .dir_x      (dir_x),
    .dir_y      (dir_y),
    .bounce     (bounce),
    .grant_col  (grant_col),
    .score      (score),
    .all_clear  (all_clear),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flags();
    col_up = '0; col_dn = '0; col_lf = '0; col_rt = '0;
  endtask

  // Present flags for one cycle; on return the DUT is in APPLY.
  task automatic pulse(input logic [7:0] u, input logic [7:0] d,
                       input logic [7:0] l, input logic [7:0] r);
    col_up = u; col_dn = d; col_lf = l; col_rt = r;
    tick();
    clear_flags();
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
  endtask

  task automatic cool_out();
    frame();
    frame();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    frame_tick = 1'b0;
    clear_flags();
    col_count = 32'h8888_8888;
    reset = 1'b1;
    tick();
    tick();
    if ({dir_x, dir_y, bounce, grant_col, drop_cnt, score, all_clear} !==
        {1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got dx=%b dy=%b b=%b g=%0d drop=%0d score=%0d clr=%b expected 1 0 0 0 0 0 0",
               dir_x, dir_y, bounce, grant_col, drop_cnt, score, all_clear);
    end
    vectors++;
    col_count = '0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_hit();
    pulse(8'h00, 8'h00, 8'h00, 8'h04);
    if (bounce !== 1'b0) begin
      miscompares++;
      $display("FAIL single_hit_early: got bounce=%b expected 0", bounce);
    end
    vectors++;
    tick();
    if ({bounce, grant_col, dir_x, dir_y} !== {1'b1, 3'd2, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL single_hit: got b/g/dx/dy=%b/%0d/%b/%b expected 1/2/1/0", bounce, grant_col, dir_x, dir_y);
    end
    vectors++;
    tick();
    if (bounce !== 1'b0) begin
      miscompares++;
      $display("FAIL single_hit_pulse: got bounce=%b expected 0", bounce);
    end
    vectors++;
    cool_out();
  endtask

  task automatic test_left_up();
    pulse(8'h10, 8'h00, 8'h10, 8'h00);
    tick();
    if ({bounce, grant_col, dir_x, dir_y} !== {1'b1, 3'd4, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL left_up: got b/g/dx/dy=%b/%0d/%b/%b expected 1/4/0/0", bounce, grant_col, dir_x, dir_y);
    end
    vectors++;
    cool_out();
  endtask

  task automatic test_conflict();
    pulse(8'h00, 8'h20, 8'h20, 8'h20);
    tick();
    if ({bounce, grant_col, dir_x, dir_y} !== {1'b1, 3'd5, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL conflict_x: got b/g/dx/dy=%b/%0d/%b/%b expected 1/5/0/1", bounce, grant_col, dir_x, dir_y);
    end
    vectors++;
    cool_out();
    pulse(8'h40, 8'h40, 8'h00, 8'h40);
    tick();
    if ({bounce, grant_col, dir_x, dir_y} !== {1'b1, 3'd6, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL conflict_y: got b/g/dx/dy=%b/%0d/%b/%b expected 1/6/1/1", bounce, grant_col, dir_x, dir_y);
    end
    vectors++;
    cool_out();
  endtask

  task automatic test_simultaneous();
    do_reset();
    pulse(8'h00, 8'h01, 8'h08, 8'h00);
    tick();
    if ({bounce, grant_col, dir_x, dir_y} !== {1'b1, 3'd0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL simul_first: got b/g/dx/dy=%b/%0d/%b/%b expected 1/0/1/1", bounce, grant_col, dir_x, dir_y);
    end
    vectors++;
    cool_out();
    pulse(8'h00, 8'h01, 8'h08, 8'h00);
    tick();
    if ({bounce, grant_col, dir_x, dir_y} !== {1'b1, 3'd3, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL simul_second: got b/g/dx/dy=%b/%0d/%b/%b expected 1/3/0/1", bounce, grant_col, dir_x, dir_y);
    end
    vectors++;
    cool_out();
    // Pointer now 4: column 5 must beat column 0.
    pulse(8'h00, 8'h00, 8'h01, 8'h20);
    tick();
    if ({bounce, grant_col, dir_x, dir_y} !== {1'b1, 3'd5, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL simul_ptr4: got b/g/dx/dy=%b/%0d/%b/%b expected 1/5/1/1", bounce, grant_col, dir_x, dir_y);
    end
    vectors++;
    cool_out();
  endtask

  task automatic test_cooldown();
    do_reset();
    pulse(8'h00, 8'h00, 8'h00, 8'h02);
    tick();
    col_up = 8'h04; tick(); clear_flags(); tick();
    frame();
    col_dn = 8'h08; tick(); clear_flags(); tick();
    col_lf = 8'h10; tick(); clear_flags(); tick();
    if ({bounce, drop_cnt} !== {1'b0, 8'd3}) begin
      miscompares++;
      $display("FAIL cool_drops: got bounce=%b drop=%0d expected 0 3", bounce, drop_cnt);
    end
    vectors++;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    // Back in IDLE: new hit accepted at once; extra edge during APPLY is ignored.
    col_rt = 8'h80;
    tick();
    col_up = 8'h01;
    tick();
    clear_flags();
    if ({bounce, grant_col, dir_x, dir_y} !== {1'b1, 3'd7, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL cool_rehit: got b/g/dx/dy=%b/%0d/%b/%b expected 1/7/1/0", bounce, grant_col, dir_x, dir_y);
    end
    vectors++;
    tick();
    if (drop_cnt !== 8'd3) begin
      miscompares++;
      $display("FAIL apply_not_dropped: got drop=%0d expected 3", drop_cnt);
    end
    vectors++;
    cool_out();
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse(8'h00, 8'h00, 8'h04, 8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if ({bounce, dir_x} !== {1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_apply: got bounce=%b dx=%b expected 0 1", bounce, dir_x);
    end
    vectors++;
    tick();
    if ({bounce, dir_x} !== {1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_apply_after: got bounce=%b dx=%b expected 0 1", bounce, dir_x);
    end
    vectors++;

    pulse(8'h00, 8'h01, 8'h01, 8'h00);
    tick();
    if ({bounce, dir_x, dir_y} !== {1'b1, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL pre_cool_hit: got b/dx/dy=%b/%b/%b expected 1/0/1", bounce, dir_x, dir_y);
    end
    vectors++;
    col_up = 8'h20; tick(); clear_flags();
    if (drop_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL cool_one_drop: got drop=%0d expected 1", drop_cnt);
    end
    vectors++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if ({dir_x, dir_y, drop_cnt, bounce} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_cool: got dx=%b dy=%b drop=%0d b=%b expected 1 0 0 0", dir_x, dir_y, drop_cnt, bounce);
    end
    vectors++;
    pulse(8'h08, 8'h00, 8'h00, 8'h00);
    tick();
    if ({bounce, grant_col, dir_x, dir_y} !== {1'b1, 3'd3, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_rehit: got b/g/dx/dy=%b/%0d/%b/%b expected 1/3/1/0", bounce, grant_col, dir_x, dir_y);
    end
    vectors++;
    cool_out();
  endtask

  task automatic test_score();
    logic [31:0] counts [4];
    logic [7:0]  exp_score [4];
    logic        exp_clear [4];
    counts[0] = 32'h8888_8888; exp_score[0] = 8'd64;  exp_clear[0] = 1'b1;
    counts[1] = 32'h8888_7888; exp_score[1] = 8'd63;  exp_clear[1] = 1'b0;
    counts[2] = 32'h8765_4321; exp_score[2] = 8'd36;  exp_clear[2] = 1'b0;
    counts[3] = 32'hFFFF_FFFF; exp_score[3] = 8'd120; exp_clear[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      col_count = counts[k];
      tick();
      if ({score, all_clear} !== {exp_score[k], exp_clear[k]}) begin
        miscompares++;
        $display("FAIL score_%0d: got score=%0d clr=%b expected %0d %b", k, score, all_clear, exp_score[k], exp_clear[k]);
      end
      vectors++;
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_left_up();
    test_conflict();
    test_simultaneous();
    test_cooldown();
    test_reset_mid();
    test_score();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/breakout_hit_arbiter.md
BREAKOUT_HIT_ARBITER -- requirements
Module: breakout_hit_arbiter

Interface
REQ-001 Parameter N_COLS, default 8: number of block-column modules feeding the arbiter.
REQ-002 Parameter COOL_FRAMES, default 2: frame ticks during which new hits are ignored after a bounce.
REQ-003 Parameter BLK_PER_COL, default 8: blocks per column, used for the clear detection.
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 frame_tick  in  1  one-cycle pulse, once per video frame.
REQ-007 col_up  in  N_COLS  per-column moveU flags, bit i from column i.
REQ-008 col_dn  in  N_COLS  per-column moveD flags.
REQ-009 col_lf  in  N_COLS  per-column moveL flags.
REQ-010 col_rt  in  N_COLS  per-column moveR flags.
REQ-011 col_count  in  4*N_COLS  per-column hit counts, column i at bits [4i+3:4i].
REQ-012 dir_x  out  1  ball horizontal direction, 1 = right.
REQ-013 dir_y  out  1  ball vertical direction, 1 = down.
REQ-014 bounce  out  1  one-cycle pulse when a direction update is applied.
REQ-015 grant_col  out  clog2(N_COLS)  index of the column granted on the latest bounce.
REQ-016 score  out  8  registered sum of all col_count fields.
REQ-017 all_clear  out  1  high while score == N_COLS*BLK_PER_COL.
REQ-018 drop_cnt  out  8  saturating count of hit events discarded during cooldown.

Function
REQ-019 A column request SHALL be req[i] = col_up[i] | col_dn[i] | col_lf[i] | col_rt[i].
REQ-020 The FSM SHALL have three states: IDLE, APPLY and COOL.
REQ-021 IDLE -> APPLY SHALL occur on any req bit set; the granted column is latched together with its four flags.
REQ-022 Grant selection SHALL be round-robin: search starts at rr_ptr and wraps modulo N_COLS; the first set bit wins.
REQ-023 After a grant, rr_ptr SHALL become (granted+1) mod N_COLS.
REQ-024 In APPLY (exactly one cycle), the latched flags SHALL update direction as follows: rt -> dir_x=1; lf -> dir_x=0; up -> dir_y=0; dn -> dir_y=1.
REQ-025 If rt and lf are both set, dir_x SHALL be unchanged; if up and dn are both set, dir_y SHALL be unchanged.
REQ-026 In APPLY, bounce SHALL be 1 and grant_col SHALL be updated; the state then moves to COOL with the cooldown counter loaded with COOL_FRAMES.
REQ-027 In COOL, each frame_tick SHALL decrement the counter; when the counter reaches 0, the state returns to IDLE on that cycle.
REQ-028 In COOL, any cycle whose req has a rising edge (req & ~req_prev nonzero) SHALL increment drop_cnt, saturating at 255; those requests SHALL NOT be queued.
REQ-029 Latency: request sampled in IDLE at cycle n -> bounce and new dir_x/dir_y visible at cycle n+2.
REQ-030 Requests present in APPLY SHALL be ignored and not counted as drops.
REQ-031 score SHALL be the 8-bit registered sum of all col_count fields, with 1-cycle latency, computed in every state.
REQ-032 all_clear SHALL be derived combinationally from the registered score.
REQ-033 A frame_tick arriving in the same cycle as APPLY SHALL NOT decrement the freshly loaded counter.

Reset
REQ-034 On reset, the following SHALL be forced on the next edge: state=IDLE, dir_x=1, dir_y=0, bounce=0, grant_col=0, rr_ptr=0, cooldown=0, score=0, drop_cnt=0, req_prev=0.
REQ-035 Reset asserted mid-APPLY or mid-COOL SHALL abort the pending update; no bounce pulse is emitted.

Structure
REQ-036 The state encoding, the COOL_FRAMES default and BLK_PER_COL SHALL live in the shared package breakout_pkg.
REQ-037 Round-robin selection SHALL be a sub-module rr_select (inputs req and ptr; outputs valid and idx, purely combinational).
REQ-038 The remaining logic SHALL be a single clocked FSM plus the score adder tree.

Verification
REQ-039 Single hit: col_rt[2]=1 for one cycle in IDLE -> bounce at n+2, grant_col=2, dir_x=1, dir_y unchanged.
REQ-040 Simultaneous hits: req=0b0000_1001 with rr_ptr=0 -> grant 0; after cooldown, the same request -> grant 3; rr_ptr then =4.
REQ-041 Cooldown: hit, then 3 new hit edges before 2 frame_ticks -> drop_cnt=3, one bounce only; state returns to IDLE on the 2nd tick.
REQ-042 Conflicting flags: col_lf[5]=col_rt[5]=1 with col_dn[5]=1 -> dir_x unchanged, dir_y=1.
REQ-043 Score/clear: all 8 col_count=8 -> score=64 and all_clear=1 one cycle later; one column=7 -> score=63, all_clear=0.
REQ-044 Reset in COOL: assert reset during cooldown -> state IDLE, dir_x=1, dir_y=0, drop_cnt=0; a new hit is accepted immediately.
